// File: rtl/stage_memory.sv
// stage_memory: MIPS memory-access stage with EX/MEM and MEM/WB registers,
// a request/ready data-memory handshake with timeout, and bypass outputs.
module stage_memory #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic             ex_memwrite,
    input  logic [WIDTH-1:0] ex_aluresult,
    input  logic [WIDTH-1:0] ex_writedata,
    input  logic [4:0]       ex_writereg,
    input  logic             ex_overflow,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic             stall_mem,
    output logic [WIDTH-1:0] aluresult_MEM,
    output logic [4:0]       writereg_MEM,
    output logic             regwrite_MEM,
    output logic [WIDTH-1:0] result_WB,
    output logic [4:0]       writereg_WB,
    output logic             regwrite_WB,
    output logic             exc_overflow,
    output logic             exc_misalign,
    output logic             exc_buserr
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_next;
    logic [7:0]       waitcnt, waitcnt_next;
    logic             mem_valid, mem_regwrite, mem_memtoreg, mem_memwrite, mem_overflow;
    logic [WIDTH-1:0] mem_aluresult, mem_writedata;
    logic [4:0]       mem_writereg;
    logic             mem_op, misaligned, aligned_op, abort, ovf_fault, mis_fault;

    assign mem_op     = mem_valid & (mem_memtoreg | mem_memwrite);
    assign misaligned = mem_aluresult[1:0] != 2'b00;
    assign aligned_op = mem_op & !misaligned;
    assign abort      = (state == WAIT) & aligned_op & !dmem_ready & (waitcnt == 8'(TIMEOUT));
    assign stall_mem  = aligned_op & !dmem_ready & !abort;
    assign ovf_fault  = mem_valid & mem_regwrite & mem_overflow;
    assign mis_fault  = mem_op & misaligned;

    assign dmem_req      = aligned_op;
    assign dmem_we       = mem_memwrite;
    assign dmem_addr     = mem_aluresult;
    assign dmem_wdata    = mem_writedata;
    assign aluresult_MEM = mem_aluresult;
    assign writereg_MEM  = mem_writereg;
    assign regwrite_MEM  = mem_valid & mem_regwrite & !mem_memtoreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid     <= 1'b0;
            mem_regwrite  <= 1'b0;
            mem_memtoreg  <= 1'b0;
            mem_memwrite  <= 1'b0;
            mem_aluresult <= '0;
            mem_writedata <= '0;
            mem_writereg  <= '0;
            mem_overflow  <= 1'b0;
        end else if (!stall_mem) begin
            mem_valid     <= ex_valid;
            mem_regwrite  <= ex_regwrite;
            mem_memtoreg  <= ex_memtoreg;
            mem_memwrite  <= ex_memwrite;
            mem_aluresult <= ex_aluresult;
            mem_writedata <= ex_writedata;
            mem_writereg  <= ex_writereg;
            mem_overflow  <= ex_overflow;
        end
    end

    always_comb begin
        state_next   = state;
        waitcnt_next = waitcnt;
        if (state == IDLE) begin
            state_next   = (aligned_op & !dmem_ready) ? WAIT : IDLE;
            waitcnt_next = (aligned_op & !dmem_ready) ? 8'd1 : 8'd0;
        end else begin
            state_next   = (dmem_ready | abort | !aligned_op) ? IDLE : WAIT;
            waitcnt_next = (dmem_ready | abort | !aligned_op) ? 8'd0 : waitcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitcnt <= '0;
        end else begin
            state   <= state_next;
            waitcnt <= waitcnt_next;
        end
    end

    // A stalled edge sends a bubble downstream; result/writereg simply hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_WB    <= '0;
            writereg_WB  <= '0;
            regwrite_WB  <= 1'b0;
            exc_overflow <= 1'b0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
        end else if (stall_mem) begin
            regwrite_WB  <= 1'b0;
            exc_overflow <= 1'b0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
        end else begin
            result_WB    <= mem_memtoreg ? dmem_rdata : mem_aluresult;
            writereg_WB  <= mem_writereg;
            regwrite_WB  <= mem_valid & mem_regwrite & !mem_memwrite & !ovf_fault & !mis_fault & !abort;
            exc_overflow <= ovf_fault;
            exc_misalign <= mis_fault;
            exc_buserr   <= abort;
        end
    end
endmodule
